// File: rtl/io_init_sequencer_pkg.sv
// rtl/io_init_sequencer_pkg.sv - shared state encoding, device indices and sizing helpers
// Purpose: one-hot FSM state type, device index constants and constant
//          functions used to size the index and counter vectors.
// Ports:   none (package).
package io_init_sequencer_pkg;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_POWERUP = 7'b000_0010,
    ST_ENABLE  = 7'b000_0100,
    ST_RELEASE = 7'b000_1000,
    ST_NEXT    = 7'b001_0000,
    ST_DONE    = 7'b010_0000,
    ST_ERROR   = 7'b100_0000
  } state_t;

  localparam int DEV_CLK = 0;
  localparam int DEV_ADC = 1;
  localparam int DEV_DAC = 2;
  localparam int DEV_MON = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A single-device build still needs a 1-bit index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_init_sequencer_if.sv
// rtl/io_init_sequencer_if.sv - handshake/status bundle between sequencer and device blocks
// Purpose: groups the start request, per-device enable/done handshake and
//          sequence status lines.
// Ports (signals):
//   init_start  request to run the sequence (level)
//   init_ena    per-device enable, one-hot while a device is being initialised
//   init_done   per-device done
//   seq_busy / seq_done / seq_error  registered sequence status
//   err_dev     index of the device that timed out
// Modports: master = sequencer side, slave = device/host side.
interface io_init_sequencer_if
  import io_init_sequencer_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int IDX_W   = idx_width(NUM_DEV)
);
  logic               init_start;
  logic [NUM_DEV-1:0] init_ena;
  logic [NUM_DEV-1:0] init_done;
  logic               seq_busy;
  logic               seq_done;
  logic               seq_error;
  logic [IDX_W-1:0]   err_dev;

  modport master (
    input  init_start, init_done,
    output init_ena, seq_busy, seq_done, seq_error, err_dev
  );

  modport slave (
    output init_start, init_done,
    input  init_ena, seq_busy, seq_done, seq_error, err_dev
  );
endinterface

// File: rtl/io_init_timer.sv
// rtl/io_init_timer.sv - loadable saturating up-counter with terminal flag
// Purpose: shared cycle counter for the powerup wait and handshake timeouts.
// Ports:
//   clk, rst_n  clock and active-low async reset
//   i_load      reload the count to zero this cycle
//   i_last      terminal count to compare against
//   o_term      high while the count equals i_last
module io_init_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_term
);
  logic [CNT_W-1:0] r_cnt;

  // Saturates at all-ones so a long idle/hold never wraps back to a
  // value that could match a terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_term = (r_cnt == i_last);
endmodule

// File: rtl/io_init_sequencer.sv
// rtl/io_init_sequencer.sv - sequences device init blocks one at a time with timeouts
// Purpose: after a powerup wait, enables each device block in index order,
//          waits for done to rise then fall, and reports done or the index
//          of the first device whose handshake timed out.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset (release synchronised internally)
//   bus    handshake/status bundle, master side
module io_init_sequencer
  import io_init_sequencer_pkg::*;
#(
  parameter int NUM_DEV        = 4,
  parameter int POWERUP_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                n_rst,
  io_init_sequencer_if.master bus
);
  localparam int IDX_W = idx_width(NUM_DEV);
  localparam int CNT_W = $clog2(max_int(POWERUP_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0]   PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DEV - 1);
  localparam logic [NUM_DEV-1:0] ENA_ONE  = NUM_DEV'(1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   r_err_dev;
  logic [NUM_DEV-1:0] r_ena;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               w_dev_done;
  logic               w_term;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_last;

  // Assertion passes straight through; release reaches the logic only
  // after two clk edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  // Only the currently selected device's done is looked at.
  assign w_dev_done = bus.init_done[r_idx];
  assign w_tmr_last = (r_state == ST_POWERUP) ? PWR_LAST : TMO_LAST;
  // Every state change restarts the count, so each phase is timed from entry.
  assign w_tmr_load = (w_state_nxt != r_state);

  io_init_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (w_rst_n),
    .i_load (w_tmr_load),
    .i_last (w_tmr_last),
    .o_term (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.init_start) begin
          w_state_nxt = ST_POWERUP;
          w_idx_nxt   = '0;
        end
      end
      ST_POWERUP: begin
        if (w_term) w_state_nxt = ST_ENABLE;
      end
      // done is tested before the timeout so a coincident done wins.
      ST_ENABLE: begin
        if (w_dev_done)  w_state_nxt = ST_RELEASE;
        else if (w_term) w_state_nxt = ST_ERROR;
      end
      ST_RELEASE: begin
        if (!w_dev_done) w_state_nxt = ST_NEXT;
        else if (w_term) w_state_nxt = ST_ERROR;
      end
      ST_NEXT: begin
        if (r_idx == IDX_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ENABLE;
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!bus.init_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ena     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_dev <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ena   <= (w_state_nxt == ST_ENABLE) ? (ENA_ONE << w_idx_nxt) : '0;
      r_busy  <= (w_state_nxt inside {ST_POWERUP, ST_ENABLE, ST_RELEASE, ST_NEXT});
      r_done  <= (w_state_nxt == ST_DONE);
      r_err   <= (w_state_nxt == ST_ERROR);
      if ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR)) begin
        r_err_dev <= r_idx;
      end
    end
  end

  assign bus.init_ena  = r_ena;
  assign bus.seq_busy  = r_busy;
  assign bus.seq_done  = r_done;
  assign bus.seq_error = r_err;
  assign bus.err_dev   = r_err_dev;
endmodule

// File: tb/tb_io_init_sequencer.sv
// tb/tb_io_init_sequencer.sv - self-checking bench for io_init_sequencer
module tb_io_init_sequencer;
  localparam int NDEV = 4;
  localparam int PWR  = 16;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  io_init_sequencer_if #(.NUM_DEV(NDEV), .IDX_W(2)) bus();

  io_init_sequencer #(
    .NUM_DEV(NDEV), .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;
  logic [3:0] ena_or;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Device block models: 0 normal (done 10 cycles after ena, clears when ena
  // drops), 1 never done, 2 done sticks high, 3 done on the 64th enabled
  // cycle, other values hold done high permanently.
  int mode [NDEV];
  int hi   [NDEV];
  initial begin
    logic [3:0] dv;
    bus.init_done = '0;
    for (int d = 0; d < NDEV; d++) begin mode[d] = 0; hi[d] = 0; end
    forever begin
      @(negedge clk);
      dv = bus.init_done;
      for (int d = 0; d < NDEV; d++) begin
        if (bus.init_ena[d]) hi[d]++; else hi[d] = 0;
        case (mode[d])
          0:       dv[d] = bus.init_ena[d] && (hi[d] >= 10);
          1:       dv[d] = 1'b0;
          2:       dv[d] = bus.init_ena[d] ? (hi[d] >= 10) : dv[d];
          3:       dv[d] = bus.init_ena[d] && (hi[d] >= 64);
          default: dv[d] = 1'b1;
        endcase
      end
      bus.init_done = dv;
    end
  end

  // Behavioural reference: walks the sequence as a procedure, one posedge
  // per step, and publishes what the outputs must be after each edge.
  logic [3:0] m_ena;
  bit         m_busy, m_done, m_err;
  int         m_err_dev;

  task automatic m_clear();
    m_ena = '0; m_busy = 0; m_done = 0; m_err = 0;
  endtask

  task automatic m_tick(output bit ab);
    @(posedge clk);
    ab = !n_rst;
  endtask

  task automatic m_hold();
    bit ab;
    forever begin
      m_tick(ab);
      if (ab || !bus.init_start) return;
    end
  endtask

  task automatic m_fail(input int d);
    m_ena = '0; m_busy = 0; m_err = 1; m_err_dev = d;
    m_hold();
  endtask

  task automatic run_seq();
    bit ab;
    bit hit;
    m_clear();
    m_busy = 1;
    repeat (PWR) begin m_tick(ab); if (ab) return; end
    for (int d = 0; d < NDEV; d++) begin
      m_ena = 4'(1 << d);
      hit = 0;
      for (int t = 0; t < TMO && !hit; t++) begin
        m_tick(ab); if (ab) return;
        hit = bus.init_done[d];
      end
      m_ena = '0;
      if (!hit) begin m_fail(d); return; end
      hit = 0;
      for (int t = 0; t < TMO && !hit; t++) begin
        m_tick(ab); if (ab) return;
        hit = !bus.init_done[d];
      end
      if (!hit) begin m_fail(d); return; end
      m_tick(ab); if (ab) return;
    end
    m_busy = 0; m_done = 1;
    m_hold();
  endtask

  initial begin
    m_clear();
    m_err_dev = 0;
    forever begin
      @(posedge clk);
      if (n_rst && bus.init_start) run_seq();
      m_clear();
    end
  end

  always @(negedge clk) begin
    if (n_rst && chk_on) begin
      check("cyc_ena",   bus.init_ena,  m_ena);
      check("cyc_busy",  bus.seq_busy,  m_busy);
      check("cyc_done",  bus.seq_done,  m_done);
      check("cyc_error", bus.seq_error, m_err);
      if (m_err) check("cyc_err_dev", bus.err_dev, m_err_dev);
    end
    ena_or = ena_or | bus.init_ena;
  end

  task automatic wait_cond(input int which, input logic [3:0] val, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      @(negedge clk);
      case (which)
        0:       if (bus.init_ena == val) at = cyc;
        1:       if (bus.seq_done)        at = cyc;
        default: if (bus.seq_error)       at = cyc;
      endcase
    end
  endtask

  task automatic expect_normal(input string tag, input int s);
    int at;
    for (int d = 0; d < NDEV; d++) begin
      wait_cond(0, 4'(1 << d), 200, at);
      check($sformatf("%s_ena%0d_time", tag, d), at - s, PWR + 12 * d);
    end
    wait_cond(1, 4'b0, 200, at);
    check({tag, "_done_time"}, at - s, 64);
    check({tag, "_no_error"}, bus.seq_error, 0);
  endtask

  task automatic go_idle();
    bus.init_start = 1'b0;
    repeat (4) @(negedge clk);
    for (int d = 0; d < NDEV; d++) mode[d] = 0;
    @(negedge clk);
  endtask

  initial begin
    int s, at, a2;
    n_rst = 1'b0;
    bus.init_start = 1'b0;
    ena_or = '0;
    repeat (4) @(negedge clk);
    check("rst_ena",     bus.init_ena,  0);
    check("rst_busy",    bus.seq_busy,  0);
    check("rst_done",    bus.seq_done,  0);
    check("rst_error",   bus.seq_error, 0);
    check("rst_err_dev", bus.err_dev,   0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_on = 1'b1;

    // Normal run, then restart from DONE with a one-cycle start drop.
    bus.init_start = 1'b1; s = cyc + 1;
    expect_normal("normal", s);
    bus.init_start = 1'b0;
    @(negedge clk);
    check("restart_left_done", bus.seq_done, 0);
    bus.init_start = 1'b1; s = cyc + 1;
    expect_normal("restart", s);
    go_idle();

    // Device 2 never answers; device 3's done is stuck high and must be ignored.
    mode[2] = 1; mode[3] = 5; ena_or = '0;
    @(negedge clk);
    bus.init_start = 1'b1; s = cyc + 1;
    wait_cond(0, 4'b0100, 200, a2);
    check("tmo_ena2_time", a2 - s, 40);
    wait_cond(2, 4'b0, 200, at);
    check("tmo_err_delay", at - a2, 64);
    check("tmo_err_dev",   bus.err_dev,  2);
    check("tmo_ena_off",   bus.init_ena, 0);
    @(negedge clk);
    check("tmo_ena_seen",  ena_or, 4'b0111);
    go_idle();

    // Device 1 keeps done high after its enable drops.
    mode[1] = 2;
    @(negedge clk);
    bus.init_start = 1'b1; s = cyc + 1;
    wait_cond(2, 4'b0, 300, at);
    check("stuck_err_time", at - s, 102);
    check("stuck_err_dev",  bus.err_dev, 1);
    go_idle();

    // Device 1 answers on the last enabled cycle, together with the timeout.
    mode[1] = 3;
    @(negedge clk);
    bus.init_start = 1'b1; s = cyc + 1;
    wait_cond(0, 4'b0100, 300, at);
    check("edge_ena2_time", at - s, 94);
    wait_cond(1, 4'b0, 200, at);
    check("edge_done_time", at - s, 118);
    check("edge_no_error",  bus.seq_error, 0);
    go_idle();

    // Reset while device 1 is enabled, then a clean rerun.
    bus.init_start = 1'b1; s = cyc + 1;
    wait_cond(0, 4'b0010, 200, at);
    check("rstmid_ena1_time", at - s, 28);
    #2;
    n_rst = 1'b0;
    bus.init_start = 1'b0;
    #1;
    check("rstmid_ena",     bus.init_ena,  0);
    check("rstmid_busy",    bus.seq_busy,  0);
    check("rstmid_done",    bus.seq_done,  0);
    check("rstmid_error",   bus.seq_error, 0);
    check("rstmid_err_dev", bus.err_dev,   0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    bus.init_start = 1'b1; s = cyc + 1;
    expect_normal("rerun", s);
    bus.init_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
